// File: rtl/ddr3_cmd_initiator.sv
// ddr3_cmd_initiator: closed-page DDR3 ACT -> RD/WR -> PRE sequencer.
// Define DDR3_MRS_INIT_EN to issue one MRS after reset before accepting requests.
module ddr3_cmd_initiator #(
    parameter int MEM_BA_WIDTH  = 3,
    parameter int MEM_ROW_WIDTH = 13,
    parameter int MEM_COL_WIDTH = 13,
    parameter int MEM_DQ_WIDTH  = 8,
    parameter int MEM_TRCD      = 11,
    parameter int MEM_TWL       = 8,
    parameter int MEM_TRL       = 6,
    parameter int MEM_RD_CAP    = 2,
    parameter int MEM_TWR       = 4,
    parameter int MEM_TRP       = 4
) (
    input  logic                      ck,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [MEM_BA_WIDTH-1:0]   req_ba,
    input  logic [MEM_ROW_WIDTH-1:0]  req_row,
    input  logic [MEM_COL_WIDTH-1:0]  req_col,
    input  logic [2*MEM_DQ_WIDTH-1:0] wr_data,
    output logic                      wr_data_req,
    input  logic [2*MEM_DQ_WIDTH-1:0] rd_data_in,
    output logic [2*MEM_DQ_WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    output logic                      cs_n,
    output logic                      ras_n,
    output logic                      cas_n,
    output logic                      we_n,
    output logic [MEM_BA_WIDTH-1:0]   ba,
    output logic [MEM_ROW_WIDTH-1:0]  a,
    output logic [2*MEM_DQ_WIDTH-1:0] dq_out,
    output logic                      dq_oe,
    output logic                      dqs_oe
);
    localparam int DW = 2 * MEM_DQ_WIDTH;
    localparam logic [3:0] CMD_DES = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [7:0] TRCD_END  = 8'(MEM_TRCD - 2);
    localparam logic [7:0] TWL8      = 8'(MEM_TWL);
    localparam logic [7:0] WR_TAIL   = 8'(MEM_TWR - 1);
    localparam logic [7:0] CAP_FIRST = 8'(MEM_TRL + MEM_RD_CAP);
    localparam logic [7:0] TRP_END   = 8'(MEM_TRP - 2);

    typedef enum logic [2:0] {
        IDLE, ACT, TRCD_WAIT, RDWR, DATA, PRE, TRP_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     wr_q, wr_d, bl8_q, bl8_d;
    logic [MEM_BA_WIDTH-1:0]  bank_q, bank_d;
    logic [MEM_ROW_WIDTH-1:0] row_q, row_d;
    logic [MEM_COL_WIDTH-1:0] col_q, col_d, col_a;
    logic [3:0]               cmd_q, cmd_d;
    logic [MEM_BA_WIDTH-1:0]  ba_q, ba_d;
    logic [MEM_ROW_WIDTH-1:0] a_q, a_d;
    logic [DW-1:0]            dq_q, dq_d, rdd_q, rdd_d;
    logic                     oe_q, oe_d, qs_q, qs_d, wreq_q, wreq_d;
    logic                     rv_q, rv_d, rdy_q, rdy_d;
    logic [7:0]               beats, wr_last, data_end;
    logic                     wphase, rd_cap;
`ifdef DDR3_MRS_INIT_EN
    logic [3:0]               init_q, init_d;
`endif

    always_comb begin
        beats    = bl8_q ? 8'd4 : 8'd2;
        wr_last  = TWL8 + beats - 8'd1;
        data_end = wr_q ? wr_last + WR_TAIL : CAP_FIRST + beats - 8'd1;
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        wr_d     = wr_q;
        bl8_d    = bl8_q;
        bank_d   = bank_q;
        row_d    = row_q;
        col_d    = col_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid && rdy_q) begin
                    state_d = ACT;
                    wr_d    = req_write;
                    bl8_d   = req_col[12];
                    bank_d  = req_ba;
                    row_d   = req_row;
                    col_d   = req_col;
                end
            end
            ACT: begin
                state_d = TRCD_WAIT;
                cnt_d   = '0;
            end
            TRCD_WAIT: if (cnt_q == TRCD_END) begin
                state_d = RDWR;
                cnt_d   = '0;
            end
            // DATA counts cycles since the RD/WR command
            RDWR: begin
                state_d = DATA;
                cnt_d   = 8'd1;
            end
            DATA: if (cnt_q == data_end) begin
                state_d = PRE;
                cnt_d   = '0;
            end
            PRE: begin
                state_d = TRP_WAIT;
                cnt_d   = '0;
            end
            TRP_WAIT: if (cnt_q == TRP_END) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed for the next cycle so the bus lines up with state_q
    always_comb begin
        cmd_d    = CMD_NOP;
        ba_d     = '0;
        a_d      = '0;
        col_a    = col_q;
        col_a[10] = 1'b0;
        unique case (state_d)
            ACT: begin
                cmd_d = CMD_ACT;
                ba_d  = bank_d;
                a_d   = row_d;
            end
            RDWR: begin
                cmd_d = wr_q ? CMD_WR : CMD_RD;
                ba_d  = bank_q;
                a_d   = MEM_ROW_WIDTH'(col_a);
            end
            PRE: begin
                cmd_d = CMD_PRE;
                ba_d  = bank_q;
            end
            default: ;
        endcase
        wphase = (state_d == DATA) && wr_q;
        oe_d   = wphase && cnt_d >= TWL8 && cnt_d <= wr_last;
        qs_d   = wphase && cnt_d >= TWL8 - 8'd1 && cnt_d <= wr_last;
        wreq_d = wphase && cnt_d >= TWL8 - 8'd1 && cnt_d < wr_last;
        dq_d   = oe_d ? wr_data : '0;
        rd_cap = (state_q == DATA) && !wr_q &&
                 cnt_q >= CAP_FIRST && cnt_q < CAP_FIRST + beats;
        rv_d   = rd_cap;
        rdd_d  = rd_cap ? rd_data_in : '0;
        rdy_d  = (state_d == IDLE);
`ifdef DDR3_MRS_INIT_EN
        init_d = (init_q == 4'd10) ? init_q : init_q + 4'd1;
        if (state_d == IDLE && init_d == 4'd5) cmd_d = CMD_MRS;
        rdy_d  = rdy_d && (init_d == 4'd10);
`endif
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            bl8_q   <= 1'b0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cmd_q   <= CMD_DES;
            ba_q    <= '0;
            a_q     <= '0;
            dq_q    <= '0;
            rdd_q   <= '0;
            oe_q    <= 1'b0;
            qs_q    <= 1'b0;
            wreq_q  <= 1'b0;
            rv_q    <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef DDR3_MRS_INIT_EN
            init_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            bl8_q   <= bl8_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            a_q     <= a_d;
            dq_q    <= dq_d;
            rdd_q   <= rdd_d;
            oe_q    <= oe_d;
            qs_q    <= qs_d;
            wreq_q  <= wreq_d;
            rv_q    <= rv_d;
            rdy_q   <= rdy_d;
`ifdef DDR3_MRS_INIT_EN
            init_q  <= init_d;
`endif
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign ba          = ba_q;
    assign a           = a_q;
    assign dq_out      = dq_q;
    assign dq_oe       = oe_q;
    assign dqs_oe      = qs_q;
    assign wr_data_req = wreq_q;
    assign rd_data     = rdd_q;
    assign rd_valid    = rv_q;
    assign req_ready   = rdy_q;
endmodule
